bank_word_sequencer: RTL and testbench
======================================

Name: bank_word_sequencer

Overview:
- Parametrised successor to the registered one-hot bank word-line decoder.
- Drives one word line of one bank at a time for a programmable pulse length.
- Supports single-word access and auto-incrementing sweep (row scan), with break-before-make gaps and a start/busy/done handshake.
- Sits between the user-area control registers and the array word-line drivers.

Parameters:
- ADDR_W, 10, word address width; word_line width is 2**ADDR_W.
- BANKS, 4, number of banks; BANK_W = clog2(BANKS), minimum 1.
- CNT_W, 8, width of the pulse and gap length counters.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  1  0 = single word (addr_start only), 1 = sweep addr_start..addr_end.
- abort  in  1  terminate any operation.
- bank_sel  in  BANK_W  target bank; latched at start.
- addr_start  in  ADDR_W  first word; latched at start.
- addr_end  in  ADDR_W  last word (sweep only); latched at start.
- pulse_len  in  CNT_W  word-line high time in cycles; latched at start.
- gap_len  in  CNT_W  low time between words in cycles; latched at start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse on normal completion.
- cur_addr  out  ADDR_W  address currently or last driven.
- word_line  out  2**ADDR_W  registered one-hot word select.
- bank_en  out  BANKS  registered one-hot bank enable; high only while word_line is high.

Behaviour:
- Reset (rst_n low at posedge): state IDLE; all outputs 0; latched operands 0. Reset mid-operation drops word_line and bank_en on that same edge.
- All outputs are registered. At most one word_line bit is high; no combinational input-to-output path.
- Effective pulse P = max(pulse_len, 1). Effective gap G = max(gap_len, 1). Guarantees at least one all-low cycle between words (break-before-make).
- States:
  - IDLE: wait for start && !abort. Latch operands; cur_addr <= addr_start; go to SETUP.
  - SETUP: one cycle with all lines low; load pulse counter with P; go to ACTIVE.
  - ACTIVE: word_line[cur_addr] and bank_en[bank] high for exactly P cycles.
    - If this is the last word (mode 0, or cur_addr == addr_end), go to DONE.
    - Otherwise go to GAP, with lines low and cur_addr incremented.
  - GAP: lines low for G cycles, then ACTIVE with a fresh P.
  - DONE: done = 1 for one cycle, busy still 1; then IDLE.
- Latency: start sampled at edge N; word line is high during cycles N+2 .. N+1+P. In single mode, done is high in cycle N+2+P.
- Sweep address arithmetic is modulo 2**ADDR_W. If addr_end < addr_start the sweep wraps through all-ones to 0. Words driven = ((addr_end - addr_start) mod 2**ADDR_W) + 1.
- abort in any non-IDLE state: at the next edge, state goes to IDLE, all lines go low, and done is not asserted. abort together with start in IDLE: start is ignored.
- start while busy is ignored, and operand inputs are not re-latched.
- bank_sel >= BANKS is latched as-is and drives no bank_en bit. word_line still pulses; cur_addr and the handshake behave normally.

Decomposition:
- Shared package bank_seq_pkg: state encoding (IDLE, SETUP, ACTIVE, GAP, DONE) and the default ADDR_W, BANKS and CNT_W constants.
- One natural sub-module, onehot_reg_decoder (parameter W): registered binary-to-one-hot decoder with synchronous active-low clear and an enable input. Instantiated twice: once for word_line (W = ADDR_W) and once for bank_en (W = BANK_W).

Test Plan:
- Reset: hold rst_n = 0 during an active pulse, with word_line[5] high -> at the next edge word_line == 0, bank_en == 0, busy == 0, done == 0.
- Single word: mode 0, bank_sel 2, addr_start 37, pulse_len 3 -> word_line[37] and bank_en[2] high for exactly 3 cycles starting 2 cycles after start; done pulses 1 cycle later; busy low afterwards.
- Sweep with gap: mode 1, 10→12, pulse_len 2, gap_len 0 -> addresses 10, 11, 12 each high for 2 cycles, separated by exactly 1 low cycle; done pulses once; cur_addr ends at 12.
- Wrap-around: ADDR_W 10, sweep 1022→1, pulse_len 1, gap_len 1 -> pulses in order 1022, 1023, 0, 1; 4 pulses total; no two word_line bits ever high together.
- Abort: sweep 0→100, assert abort on the 2nd ACTIVE cycle of word 3 -> all lines low next cycle, no done, back in IDLE; a new start is accepted the following cycle.
- Ignored start: pulse start with different operands while busy -> running sequence unchanged; a start together with abort in IDLE -> busy stays 0.

Source files
------------

// File: rtl/bank_seq_pkg.sv
// Shared types and default sizing for the bank word-line sequencer.
package bank_seq_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned BANKS_DEF  = 4;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACTIVE,
    GAP,
    DONE
  } state_e;

endpackage

// File: rtl/bank_word_sequencer_onehot.sv
// Registered binary-to-one-hot decoder with synchronous active-low clear.
// N output bits; an index with no matching bit (idx >= N) drives all zeros.
module onehot_reg_decoder #(
  parameter int unsigned W = 1,
  parameter int unsigned N = (1 << W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  logic [N-1:0] onehot_d;
  logic [N-1:0] onehot_q;

  // Decode the index into a single set bit while enabled.
  always_comb begin
    onehot_d = '0;
    if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (idx == W'(i)) onehot_d[i] = 1'b1;
      end
    end
  end

  // Output register, cleared synchronously.
  always_ff @(posedge clk) begin
    if (!rst_n) onehot_q <= '0;
    else        onehot_q <= onehot_d;
  end

  assign onehot = onehot_q;

endmodule

// File: rtl/bank_word_sequencer.sv
// Bank word-line sequencer: single-word or auto-incrementing sweep with
// programmable pulse and break-before-make gap lengths.
module bank_word_sequencer
  import bank_seq_pkg::*;
#(
  parameter  int unsigned ADDR_W = ADDR_W_DEF,
  parameter  int unsigned BANKS  = BANKS_DEF,
  parameter  int unsigned CNT_W  = CNT_W_DEF,
  localparam int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     abort,
  input  logic [BANK_W-1:0]        bank_sel,
  input  logic [ADDR_W-1:0]        addr_start,
  input  logic [ADDR_W-1:0]        addr_end,
  input  logic [CNT_W-1:0]         pulse_len,
  input  logic [CNT_W-1:0]         gap_len,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        cur_addr,
  output logic [(1<<ADDR_W)-1:0]   word_line,
  output logic [BANKS-1:0]         bank_en
);

  state_e              state_q, state_d;
  logic                mode_q,  mode_d;
  logic [BANK_W-1:0]   bank_q,  bank_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [ADDR_W-1:0]   end_q,   end_d;
  logic [CNT_W-1:0]    pulse_q, pulse_d;
  logic [CNT_W-1:0]    gap_q,   gap_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [CNT_W-1:0]    eff_pulse;
  logic [CNT_W-1:0]    eff_gap;
  logic                lines_en;

  // State and operand registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      bank_q  <= '0;
      addr_q  <= '0;
      end_q   <= '0;
      pulse_q <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      pulse_q <= pulse_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, operand latch and pulse/gap counter.
  always_comb begin
    eff_pulse = (pulse_q == '0) ? CNT_W'(1) : pulse_q;
    eff_gap   = (gap_q   == '0) ? CNT_W'(1) : gap_q;
    state_d   = state_q;
    mode_d    = mode_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    end_d     = end_q;
    pulse_d   = pulse_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mode_d  = mode;
          bank_d  = bank_sel;
          addr_d  = addr_start;
          end_d   = addr_end;
          pulse_d = pulse_len;
          gap_d   = gap_len;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = eff_pulse;
        state_d = ACTIVE;
      end
      ACTIVE: begin
        if (cnt_q == CNT_W'(1)) begin
          if (!mode_q || (addr_q == end_q)) begin
            state_d = DONE;
          end else begin
            state_d = GAP;
            addr_d  = addr_q + 1'b1;
            cnt_d   = eff_gap;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ACTIVE;
          cnt_d   = eff_pulse;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      addr_d  = addr_q;
    end
  end

  // Handshake outputs decode straight from the state register.
  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    cur_addr = addr_q;
    lines_en = (state_d == ACTIVE);
  end

  // Decoders are fed next-state values so their registered outputs line up
  // with the ACTIVE state and drop on the same edge as abort or reset.
  onehot_reg_decoder #(
    .W (ADDR_W),
    .N (1 << ADDR_W)
  ) u_word_dec (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (lines_en),
    .idx    (addr_d),
    .onehot (word_line)
  );

  onehot_reg_decoder #(
    .W (BANK_W),
    .N (BANKS)
  ) u_bank_dec (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (lines_en),
    .idx    (bank_d),
    .onehot (bank_en)
  );

endmodule

// File: tb/tb_bank_word_sequencer.sv
// Scoreboard bench for bank_word_sequencer: stimulus pushes expected word-line
// pulses and done events; a negedge monitor pops and compares them.
module tb_bank_word_sequencer;

  localparam int NW = 1024;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            mode = 1'b0;
  logic            abort = 1'b0;
  logic [1:0]      bank_sel = '0;
  logic [9:0]      addr_start = '0;
  logic [9:0]      addr_end = '0;
  logic [7:0]      pulse_len = '0;
  logic [7:0]      gap_len = '0;
  logic            busy;
  logic            done;
  logic [9:0]      cur_addr;
  logic [NW-1:0]   word_line;
  logic [3:0]      bank_en;

  bank_word_sequencer #(
    .ADDR_W (10),
    .BANKS  (4),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .abort      (abort),
    .bank_sel   (bank_sel),
    .addr_start (addr_start),
    .addr_end   (addr_end),
    .pulse_len  (pulse_len),
    .gap_len    (gap_len),
    .busy       (busy),
    .done       (done),
    .cur_addr   (cur_addr),
    .word_line  (word_line),
    .bank_en    (bank_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int addr;
    int bank_en;
    int cyc;
    int len;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 0;

  // Monitor-side pulse tracking
  bit in_pulse = 0;
  int p_addr, p_start, p_len, p_bank;
  bit p_bank_bad;

  function automatic void push_pulse(int addr, int bank_oh, int c, int len);
    exp_t e;
    e.is_done = 0; e.addr = addr; e.bank_en = bank_oh; e.cyc = c; e.len = len;
    expq.push_back(e);
  endfunction

  function automatic void push_done(int addr, int c);
    exp_t e;
    e.is_done = 1; e.addr = addr; e.bank_en = 0; e.cyc = c; e.len = 0;
    expq.push_back(e);
  endfunction

  // Reference model: start sampled at edge s -> pulse i visible from cycle
  // s+1+i*(P+G) for P cycles; done visible right after the last pulse.
  function automatic void push_expect(bit m, int b, int as, int ae, int pl, int gl, int s);
    int n, p, g, boh;
    n   = m ? (((ae - as) & (NW - 1)) + 1) : 1;
    p   = (pl == 0) ? 1 : pl;
    g   = (gl == 0) ? 1 : gl;
    boh = (b < 4) ? (1 << b) : 0;
    for (int i = 0; i < n; i++)
      push_pulse((as + i) & (NW - 1), boh, s + 1 + i * (p + g), p);
    push_done((as + n - 1) & (NW - 1), s + 1 + n * p + (n - 1) * g);
  endfunction

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic close_pulse();
    exp_t e;
    in_pulse = 0;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL pulse_unexpected: got addr %0d bank_en %0d start %0d len %0d, required none",
               p_addr, p_bank, p_start, p_len);
      return;
    end
    e = expq.pop_front();
    if (e.is_done || e.addr != p_addr || e.bank_en != p_bank || e.cyc != p_start ||
        e.len != p_len || p_bank_bad) begin
      fails++;
      $display("FAIL pulse: got addr %0d bank_en %0d start %0d len %0d bank_glitch %0d, required %s addr %0d bank_en %0d start %0d len %0d",
               p_addr, p_bank, p_start, p_len, p_bank_bad, e.is_done ? "done" : "pulse",
               e.addr, e.bank_en, e.cyc, e.len);
    end
  endtask

  // Monitor: sample outputs away from the active edge, pop and compare.
  always @(negedge clk) begin
    if (mon_en) begin
      if (word_line != '0) begin
        int idx;
        idx = -1;
        for (int i = NW - 1; i >= 0; i--) if (word_line[i]) idx = i;
        tests++;
        if (!$onehot(word_line)) begin
          fails++;
          $display("FAIL onehot: %0d word lines high at cycle %0d, required 1",
                   $countones(word_line), cyc);
        end
        if (in_pulse && idx != p_addr) close_pulse();
        if (!in_pulse) begin
          in_pulse = 1; p_addr = idx; p_start = cyc; p_len = 1;
          p_bank = int'(bank_en); p_bank_bad = 0;
        end else begin
          p_len++;
          if (int'(bank_en) != p_bank) p_bank_bad = 1;
        end
      end else begin
        if (in_pulse) close_pulse();
        if (bank_en != '0) begin
          tests++;
          fails++;
          $display("FAIL bank_en_without_word: got %0d at cycle %0d, required 0", bank_en, cyc);
        end
      end
      if (done) begin
        exp_t e;
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected: got done at cycle %0d cur_addr %0d, required none", cyc, cur_addr);
        end else begin
          e = expq.pop_front();
          if (!e.is_done || e.cyc != cyc || e.addr != int'(cur_addr) || busy !== 1'b1) begin
            fails++;
            $display("FAIL done: got cycle %0d cur_addr %0d busy %0b, required %s cycle %0d cur_addr %0d busy 1",
                     cyc, cur_addr, busy, e.is_done ? "done" : "pulse", e.cyc, e.addr);
          end
        end
      end
    end
  end

  task automatic issue_start(bit m, int b, int as, int ae, int pl, int gl, output int s);
    mode = m; bank_sel = 2'(b); addr_start = 10'(as); addr_end = 10'(ae);
    pulse_len = 8'(pl); gap_len = 8'(gl);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_idle(string name);
    for (int i = 0; i < 3000 && busy; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic wait_cyc(int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_word_line", int'(word_line != '0), 0);
    check("rst_bank_en", int'(bank_en), 0);
    check("rst_cur_addr", int'(cur_addr), 0);
    rst_n = 1'b1;
    mon_en = 1;
    @(posedge clk); #1;

    // Single word: bank 2, addr 37, P=3 -> pulse cycles s+1..s+3, done s+4
    issue_start(0, 2, 37, 0, 3, 0, s);
    push_expect(0, 2, 37, 0, 3, 0, s);
    wait_idle("single");
    check("single_cur_addr", int'(cur_addr), 37);

    // Sweep 10..12, P=2, gap_len 0 -> effective gap 1
    issue_start(1, 1, 10, 12, 2, 0, s);
    push_expect(1, 1, 10, 12, 2, 0, s);
    wait_idle("sweep");
    check("sweep_cur_addr", int'(cur_addr), 12);

    // Wrap-around 1022..1, P=1, G=1 -> 1022,1023,0,1
    issue_start(1, 3, 1022, 1, 1, 1, s);
    push_expect(1, 3, 1022, 1, 1, 1, s);
    wait_idle("wrap");
    check("wrap_cur_addr", int'(cur_addr), 1);

    // pulse_len 0 behaves as 1, gap_len 3
    issue_start(1, 0, 200, 201, 0, 3, s);
    push_expect(1, 0, 200, 201, 0, 3, s);
    wait_idle("zero_pulse");

    // Abort on 2nd ACTIVE cycle of third word (addr 2), P=3 G=2
    issue_start(1, 0, 0, 100, 3, 2, s);
    push_pulse(0, 1, s + 1, 3);
    push_pulse(1, 1, s + 6, 3);
    push_pulse(2, 1, s + 11, 2);
    wait_cyc(s + 12);
    check("abort_pre_word2", int'(word_line[2]), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_lines", int'(word_line != '0), 0);
    check("abort_cur_addr", int'(cur_addr), 2);
    // New start accepted immediately
    issue_start(0, 1, 3, 0, 1, 0, s);
    push_expect(0, 1, 3, 0, 1, 0, s);
    check("restart_busy", int'(busy), 1);
    wait_idle("restart");

    // Start while busy is ignored
    issue_start(1, 0, 5, 6, 2, 1, s);
    push_expect(1, 0, 5, 6, 2, 1, s);
    mode = 1'b0; bank_sel = 2'd3; addr_start = 10'd900; addr_end = 10'd901;
    pulse_len = 8'd7; gap_len = 8'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("busy_start");
    check("busy_start_cur_addr", int'(cur_addr), 6);

    // Start together with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", int'(busy), 0);
    repeat (4) @(posedge clk);
    #1;
    check("start_abort_still_idle", int'(busy), 0);

    // Reset mid-pulse with word_line[5] high
    issue_start(0, 1, 5, 0, 10, 0, s);
    push_pulse(5, 2, s + 1, 3);
    wait_cyc(s + 3);
    check("reset_pre_word5", int'(word_line[5]), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_word_line", int'(word_line != '0), 0);
    check("reset_bank_en", int'(bank_en), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_cur_addr", int'(cur_addr), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
